pc_fetch_unit: RTL and testbench

//  Instruction-fetch front end sitting directly upstream of IF_ID. Owns the PC,

---
 rtl/pc_fetch_unit_pkg.sv | 9 +
 rtl/pc_fetch_unit_fetch_queue.sv | 59 +++++
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
package pc_fetch_unit_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INSN_BYTES   = 4;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit_fetch_queue.sv
// Small synchronous FIFO with flush; used for both the instruction queue and
// the address-tag queue of outstanding ROM requests.
module fetch_queue
  import pc_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, issues in-order ROM reads, queues returned
// words with their PCs and hands {instruction, PC, valid} to IF_ID.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              QDEPTH   = 2,
  parameter int              MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            resetIn,
  input  logic            locker,
  input  logic            redirValid,
  input  logic [XLEN-1:0] redirTarget,
  output logic            romReq,
  output logic [XLEN-1:0] romAddr,
  input  logic            romRdy,
  input  logic            romValid,
  input  logic [XLEN-1:0] romData,
  output logic [XLEN-1:0] dataOut,
  output logic [XLEN-1:0] addrOut,
  output logic            validOut,
  output logic            resetOut
);

  localparam int            CW    = $clog2(QDEPTH) + 1;
  localparam logic [CW:0]   QD_W  = (CW + 1)'(QDEPTH);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_OUT);

  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     kill;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     q_count;
  logic [CW:0]       occupancy;
  logic              rom_fire;
  logic              capture;
  logic              pop;
  logic [XLEN-1:0]   tag_head;
  logic              tag_full;
  logic              tag_empty;
  logic [2*XLEN-1:0] q_head;
  logic              q_full;
  logic              q_empty;
  logic [XLEN-1:0]   last_data;
  logic [XLEN-1:0]   last_addr;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  // Slots already promised (queued words plus outstanding requests) bound issue,
  // so every live response is guaranteed a queue entry.
  assign occupancy = {1'b0, inflight} + {1'b0, q_count};
  assign romReq    = !resetIn && !redirValid && (occupancy < QD_W) && (inflight < MAX_W);
  assign romAddr   = pc;
  assign rom_fire  = romReq && romRdy;
  // Responses owed to a squashed stream are discarded while kill is non-zero.
  assign capture   = romValid && (kill == '0) && !redirValid && !resetIn;
  assign pop       = validOut && locker && !redirValid && !resetIn;

  assign validOut  = !q_empty;
  assign dataOut   = validOut ? q_head[XLEN-1:0]    : last_data;
  assign addrOut   = validOut ? q_head[2*XLEN-1:XLEN] : last_addr;

  // PCs of outstanding live requests; its occupancy is the in-flight count.
  fetch_queue #(.DEPTH(QDEPTH), .W(XLEN)) u_tag_q (
    .clk       (clk),
    .rst       (resetIn),
    .push      (rom_fire),
    .push_data (pc),
    .pop       (capture),
    .flush     (redirValid),
    .head      (tag_head),
    .count     (inflight),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Returned instructions paired with their PCs, head presented to IF_ID.
  fetch_queue #(.DEPTH(QDEPTH), .W(2 * XLEN)) u_insn_q (
    .clk       (clk),
    .rst       (resetIn),
    .push      (capture),
    .push_data ({tag_head, romData}),
    .pop       (pop),
    .flush     (redirValid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // PC: reset vector, redirect target (word aligned), or advance on each accepted request.
  always_ff @(posedge clk) begin
    if (resetIn)         pc <= RESET_PC;
    else if (redirValid) pc <= word_align(redirTarget);
    else if (rom_fire)   pc <= pc + XLEN'(INSN_BYTES);
  end

  // Stale-response counter: a redirect turns everything outstanding into kills,
  // less the response (live or stale) consumed in the redirect cycle itself.
  always_ff @(posedge clk) begin
    if (resetIn)                      kill <= '0;
    else if (redirValid)              kill <= kill + inflight - CW'(romValid);
    else if (romValid && kill != '0)  kill <= kill - 1'b1;
  end

  // Last instruction handed over, shown while the queue is empty.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      last_data <= '0;
      last_addr <= '0;
    end else if (pop) begin
      last_data <= q_head[XLEN-1:0];
      last_addr <= q_head[2*XLEN-1:XLEN];
    end
  end

  // Reset forwarded to IF_ID one cycle late.
  always_ff @(posedge clk) begin
    resetOut <= resetIn;
  end

  // Protocol guards: no response without an outstanding request, no FIFO overrun.
  a_rsp_owed : assert property (@(posedge clk) disable iff (resetIn)
    !(romValid && inflight == '0 && kill == '0));
  a_tag_room : assert property (@(posedge clk) disable iff (resetIn)
    !(rom_fire && tag_full));
  a_tag_rsp  : assert property (@(posedge clk) disable iff (resetIn)
    !(capture && tag_empty));
  a_q_room   : assert property (@(posedge clk) disable iff (resetIn)
    !(capture && q_full && !pop));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: randomized ROM timing, stalls and redirects against a
// program-order reference (after reset/redirect to T the stream is T, T+4, ...).
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] addr;
    int          ready;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetIn, locker, redirValid, romRdy, romValid, romReq, validOut, resetOut;
  logic [31:0] redirTarget, romAddr, romData, dataOut, addrOut;
  logic        locker2, redirValid2, romRdy2, romValid2, romReq2, validOut2, resetOut2;
  logic [31:0] redirTarget2, romAddr2, romData2, dataOut2, addrOut2;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(2), .MAX_OUT(2)) dut (
    .clk(clk), .resetIn(resetIn), .locker(locker), .redirValid(redirValid),
    .redirTarget(redirTarget), .romReq(romReq), .romAddr(romAddr), .romRdy(romRdy),
    .romValid(romValid), .romData(romData), .dataOut(dataOut), .addrOut(addrOut),
    .validOut(validOut), .resetOut(resetOut)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(2), .MAX_OUT(2)) dut_wrap (
    .clk(clk), .resetIn(resetIn), .locker(locker2), .redirValid(redirValid2),
    .redirTarget(redirTarget2), .romReq(romReq2), .romAddr(romAddr2), .romRdy(romRdy2),
    .romValid(romValid2), .romData(romData2), .dataOut(dataOut2), .addrOut(addrOut2),
    .validOut(validOut2), .resetOut(resetOut2)
  );

  int checks = 0;
  int failures = 0;

  // knobs written only by the main sequence
  bit          rst_req = 1'b1;
  int          lat_fixed = 1;
  bit          rdy_rand = 1'b0;
  int          lock_mode = 1;
  bit          rand_events = 1'b0;
  logic [31:0] stall_pc = 32'h0;
  int          stall_budget = 0;
  int          redir_req_n = 0;
  logic [31:0] redir_tgt = 32'h0;
  int          busy_req_n = 0;

  // state written only by the driver
  int          stall_spent = 0;
  int          redir_done_n = 0;
  int          busy_done_n = 0;
  int          cyc = 0;
  int          last_ready = 0;
  req_t        pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] exp_next = 32'h0;
  logic [31:0] exp2_next = 32'hFFFF_FFF8;
  bit          p2v = 1'b0;
  logic [31:0] p2a = 32'h0;

  // state written only by the monitor
  int n_pops = 0;
  bit prev_redir = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  // Driver: ROM models, locker, redirects and the expected program-order streams.
  initial begin
    req_t h;
    int lat;
    int r;
    resetIn = 1'b1; locker = 1'b1; redirValid = 1'b0; redirTarget = '0;
    romRdy = 1'b1; romValid = 1'b0; romData = '0;
    locker2 = 1'b1; redirValid2 = 1'b0; redirTarget2 = '0;
    romRdy2 = 1'b1; romValid2 = 1'b0; romData2 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      resetIn = rst_req || (rand_events && $urandom_range(0, 199) == 0);
      romValid = 1'b0;
      if (resetIn) begin
        pend.delete();
        last_ready = 0;
      end else if (pend.size() > 0 && pend[0].ready <= cyc) begin
        h = pend.pop_front();
        romValid = 1'b1;
        romData = rom_word(h.addr);
      end
      romValid2 = !resetIn && p2v;
      romData2 = rom_word(p2a);
      romRdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      locker = (lock_mode == 2) ? 1'($urandom_range(0, 1)) : (lock_mode == 1);
      if (stall_spent < stall_budget && validOut && addrOut == stall_pc) begin
        locker = 1'b0;
        stall_spent++;
      end
      redirValid = 1'b0;
      if (!resetIn) begin
        if (redir_done_n < redir_req_n) begin
          redirValid = 1'b1; redirTarget = redir_tgt; redir_done_n++;
        end else if (busy_done_n < busy_req_n && romValid && validOut && locker) begin
          redirValid = 1'b1; redirTarget = $urandom; busy_done_n++;
        end else if (rand_events && $urandom_range(0, 15) == 0) begin
          redirValid = 1'b1; redirTarget = $urandom;
        end
      end
      #1;
      if (resetIn) begin
        exp_q.delete(); exp_next = 32'h0;
        exp2_q.delete(); exp2_next = 32'hFFFF_FFF8;
      end else if (redirValid) begin
        exp_q.delete(); exp_next = redirTarget & ~32'd3;
      end
      while (exp_q.size() < 8) begin exp_q.push_back(exp_next); exp_next += 32'd4; end
      while (exp2_q.size() < 8) begin exp2_q.push_back(exp2_next); exp2_next += 32'd4; end
      if (!resetIn && romReq && romRdy) begin
        lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 3);
        r = cyc + lat;
        if (r <= last_ready) r = last_ready + 1;
        pend.push_back('{addr: romAddr, ready: r});
        last_ready = r;
      end
      p2v = !resetIn && romReq2;
      p2a = romAddr2;
    end
  end

  // Monitor: whenever a word is presented it must be the next one in program order.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (resetIn) begin
        prev_redir = 1'b0;
      end else begin
        if (prev_redir) chk("flush_valid", {31'b0, validOut}, 32'd0);
        if (validOut && !redirValid) begin
          if (exp_q.size() == 0) begin
            chk("exp_empty", 32'd0, 32'd1);
          end else begin
            e = exp_q[0];
            chk("head_addr", addrOut, e);
            chk("head_data", dataOut, rom_word(e));
            if (locker) begin
              void'(exp_q.pop_front());
              n_pops++;
            end
          end
        end
        if (validOut2) begin
          if (exp2_q.size() == 0) begin
            chk("wrap_exp_empty", 32'd0, 32'd1);
          end else begin
            e = exp2_q.pop_front();
            chk("wrap_addr", addrOut2, e);
            chk("wrap_data", dataOut2, rom_word(e));
          end
        end
        prev_redir = redirValid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Main sequence of directed scenarios followed by a randomized run.
  initial begin
    int k;
    int pops0;
    bit seen;

    // Reset held three cycles
    rst_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_romReq", {31'b0, romReq}, 32'd0);
      chk("rst_romAddr", romAddr, 32'h0);
      chk("rst_valid", {31'b0, validOut}, 32'd0);
      chk("rst_resetOut", {31'b0, resetOut}, 32'd1);
    end
    chk("rst_dataOut", dataOut, 32'h0);
    chk("rst_addrOut", addrOut, 32'h0);
    chk("rst_resetOut2", {31'b0, resetOut2}, 32'd1);
    chk("rst_wrap_romAddr", romAddr2, 32'hFFFF_FFF8);
    rst_req = 1'b0;
    tick();
    chk("rel_romReq", {31'b0, romReq}, 32'd1);
    chk("rel_resetOut", {31'b0, resetOut}, 32'd1);
    chk("rel_valid", {31'b0, validOut}, 32'd0);
    tick();
    chk("rel1_resetOut", {31'b0, resetOut}, 32'd0);
    chk("rel1_valid", {31'b0, validOut}, 32'd0);
    tick();
    chk("first_valid", {31'b0, validOut}, 32'd1);
    chk("first_addr", addrOut, 32'h0);
    chk("first_data", dataOut, rom_word(32'h0));
    chk("first_wrap_addr", addrOut2, 32'hFFFF_FFF8);

    // Streaming with latency-1 ROM
    pops0 = n_pops;
    repeat (40) tick();
    chk("stream_live", {31'b0, (n_pops - pops0) >= 10}, 32'd1);

    // Stall at PC 0x8 for five cycles
    rst_req = 1'b1;
    repeat (2) tick();
    stall_pc = 32'h8;
    stall_budget = stall_budget + 5;
    rst_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (stall_spent == stall_budget) seen = 1'b1;
    end
    chk("stall_reached", {31'b0, seen}, 32'd1);
    chk("stall_valid", {31'b0, validOut}, 32'd1);
    chk("stall_addr", addrOut, 32'h8);
    chk("stall_romReq", {31'b0, romReq}, 32'd0);
    repeat (20) tick();

    // Redirect with two requests in flight, ROM latency 3
    lat_fixed = 3;
    rst_req = 1'b1;
    repeat (2) tick();
    rst_req = 1'b0;
    tick();
    tick();
    redir_tgt = 32'h0000_0103;
    redir_req_n++;
    tick();
    chk("redir_romReq", {31'b0, romReq}, 32'd0);
    tick();
    chk("redir_romAddr", romAddr, 32'h100);
    chk("redir_restart", {31'b0, romReq}, 32'd1);
    chk("redir_flushed", {31'b0, validOut}, 32'd0);
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (validOut) begin seen = 1'b1; k = i; end
    end
    chk("redir_seen", {31'b0, seen}, 32'd1);
    chk("redir_latency", k, 32'd4);
    chk("redir_first_addr", addrOut, 32'h100);
    repeat (20) tick();

    // Redirect coinciding with a response and a pop
    lat_fixed = 1;
    busy_req_n++;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (busy_done_n == busy_req_n) seen = 1'b1;
    end
    chk("busy_redir_hit", {31'b0, seen}, 32'd1);
    repeat (20) tick();

    // Randomized run
    lat_fixed = 0;
    rdy_rand = 1'b1;
    lock_mode = 2;
    rand_events = 1'b1;
    pops0 = n_pops;
    repeat (3000) tick();
    chk("random_live", {31'b0, (n_pops - pops0) >= 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
